// File: rtl/mem_fifo_pkg.sv
// Shared types and constants for the MEMIF fifo controller.
// Output buffer sizing and depth helper.
package mem_fifo_pkg;

  localparam int OBUF_DEPTH = 2;

  typedef logic [1:0] obuf_cnt_t;
  typedef logic       obuf_idx_t;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/mem_fifo_ctrl_if.sv
// MEMIF fifo-memory port: controller drives writes and read address,
// memory returns registered read data.
interface mem_fifo_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
);
  logic [AWIDTH-1:0] f0_waddr;
  logic [DWIDTH-1:0] f0_wdata;
  logic              f0_write;
  logic [AWIDTH-1:0] f0_raddr;
  logic [DWIDTH-1:0] f0_rdata;

  modport master (
    output f0_waddr, f0_wdata, f0_write, f0_raddr,
    input  f0_rdata
  );

  modport slave (
    input  f0_waddr, f0_wdata, f0_write, f0_raddr,
    output f0_rdata
  );
endinterface

// File: rtl/mem_fifo_obuf.sv
// Two-entry output buffer: captures returning read data at the tail,
// presents the head for first-word-fall-through pops.
module mem_fifo_obuf
  import mem_fifo_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_valid,
  input  logic [DWIDTH-1:0] cap_data,
  input  logic              pop_fire,
  output logic [DWIDTH-1:0] head_data,
  output obuf_cnt_t         cnt
);

  logic [DWIDTH-1:0] slot [OBUF_DEPTH];
  obuf_idx_t         head;
  obuf_idx_t         tail;

  // Capture never arrives while full, so tail is head or its partner.
  assign tail      = head ^ cnt[0];
  assign head_data = slot[head];

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= 1'b0;
      cnt  <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        slot[i] <= '0;
      end
    end else begin
      if (cap_valid) begin
        slot[tail] <= cap_data;
      end
      if (pop_fire) begin
        head <= ~head;
      end
      cnt <= cnt + obuf_cnt_t'(cap_valid)
                 - obuf_cnt_t'(pop_fire);
    end
  end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller over a synchronous-read memory; a small output buffer
// hides the read latency so pops can stream at one word per cycle.
module mem_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [DWIDTH-1:0]   push_data,
  output logic                pop_valid,
  input  logic                pop_ready,
  output logic [DWIDTH-1:0]   pop_data,
  output logic [AWIDTH+1:0]   occupancy,
  mem_fifo_ctrl_if.master     mem
);

  localparam int              DEPTH = fifo_depth(AWIDTH);
  localparam logic [AWIDTH:0] FULL  = (AWIDTH+1)'(DEPTH);

  logic [AWIDTH-1:0] wptr;
  logic [AWIDTH-1:0] rptr;
  logic [AWIDTH:0]   mem_count;
  logic              rd_pend;
  obuf_cnt_t         obuf_cnt;
  logic              push_fire;
  logic              pop_fire;
  logic              rd_issue;
  logic [2:0]        inflight;

  assign push_ready = rst & (mem_count != FULL);
  assign push_fire  = push_valid & push_ready;
  assign pop_valid  = rst & (obuf_cnt != '0);
  assign pop_fire   = pop_valid & pop_ready;

  // Reads in flight plus buffered words must leave room after this pop.
  assign inflight = {1'b0, obuf_cnt} + {2'b0, rd_pend};
  assign rd_issue = rst & (mem_count != '0)
                  & (inflight < 3'd2 + {2'b0, pop_fire});

  assign mem.f0_write = push_fire;
  assign mem.f0_waddr = rst ? wptr : '0;
  assign mem.f0_wdata = push_data;
  assign mem.f0_raddr = rst ? rptr : '0;

  assign occupancy = rst ? ({1'b0, mem_count}
                            + (AWIDTH+2)'(rd_pend)
                            + (AWIDTH+2)'(obuf_cnt))
                         : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      mem_count <= '0;
      rd_pend   <= 1'b0;
    end else begin
      wptr      <= wptr + AWIDTH'(push_fire);
      rptr      <= rptr + AWIDTH'(rd_issue);
      mem_count <= mem_count + (AWIDTH+1)'(push_fire)
                             - (AWIDTH+1)'(rd_issue);
      rd_pend   <= rd_issue;
    end
  end

  mem_fifo_obuf #(
    .DWIDTH (DWIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .cap_valid (rd_pend),
    .cap_data  (mem.f0_rdata),
    .pop_fire  (pop_fire),
    .head_data (pop_data),
    .cnt       (obuf_cnt)
  );

endmodule
